// File: rtl/piezo_arbiter.sv
// piezo_arbiter: shares one piezo driver between the alarm FSM and keypad beeps.
// Alarm notes pass through live while the alarm holds the grant; key presses
// play a fixed-length beep; every grant is followed by a timed silent gap.
// Optional build macro KEY_PREEMPT_EN: a pending key press cuts an active alarm
// short (alarm -> gap -> beep -> gap -> alarm again if still requested).
// Without it, a key press waits until the alarm releases the speaker.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | speaker free; pending key wins over alarm request
// ALARM | alarm owns speaker; alarm_note passed through (1 clk late)
// BEEP  | key beep playing latched note for BEEP_TICKS ticks
// GAP   | silence for GAP_TICKS ticks before next arbitration
module piezo_arbiter #(
  parameter int unsigned BEEP_TICKS = 5,
  parameter int unsigned GAP_TICKS  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        alarm_req,
  input  logic [12:0] alarm_note,
  input  logic        key_req,
  input  logic [12:0] key_note,
  output logic [12:0] play_sound,
  output logic        grant_alarm,
  output logic        grant_key,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALARM = 2'd1,
    BEEP  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [7:0] BEEP_N = 8'(BEEP_TICKS);
  localparam logic [7:0] GAP_N  = 8'(GAP_TICKS);

  state_t      state;
  logic [7:0]  cnt;
  logic        pend;
  logic [12:0] note_q;

  logic        key_hit;
  logic [12:0] key_sel;
  logic        alarm_exit;
  logic        cnt_done;

  // A key press in the same cycle as the IDLE decision counts as pending,
  // so a simultaneous key/alarm request resolves to the beep.
  always_comb begin
    key_hit    = pend | key_req;
    key_sel    = pend ? note_q : key_note;
    cnt_done   = tick && (cnt == 8'd1);
`ifdef KEY_PREEMPT_EN
    alarm_exit = !alarm_req || pend;
`else
    alarm_exit = !alarm_req;
`endif
  end

  // Arbitration FSM with duration down-counter, one-deep key latch and
  // registered speaker/grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      pend        <= 1'b0;
      note_q      <= 13'd0;
      play_sound  <= 13'd0;
      grant_alarm <= 1'b0;
      grant_key   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // Later presses while one is waiting are dropped; first note is kept.
      if (key_req && !pend) begin
        pend   <= 1'b1;
        note_q <= key_note;
      end

      case (state)
        IDLE: begin
          if (key_hit) begin
            state      <= BEEP;
            cnt        <= BEEP_N;
            pend       <= 1'b0;
            note_q     <= key_sel;
            play_sound <= key_sel;
            grant_key  <= 1'b1;
            busy       <= 1'b1;
          end else if (alarm_req) begin
            state       <= ALARM;
            play_sound  <= alarm_note;
            grant_alarm <= 1'b1;
            busy        <= 1'b1;
          end else begin
            play_sound <= 13'd0;
          end
        end

        ALARM: begin
          if (alarm_exit) begin
            state       <= GAP;
            cnt         <= GAP_N;
            play_sound  <= 13'd0;
            grant_alarm <= 1'b0;
          end else begin
            play_sound <= alarm_note;
          end
        end

        BEEP: begin
          if (cnt_done) begin
            state      <= GAP;
            cnt        <= GAP_N;
            play_sound <= 13'd0;
            grant_key  <= 1'b0;
          end else if (tick && (cnt > 8'd1)) begin
            cnt <= cnt - 8'd1;
          end
        end

        GAP: begin
          if (cnt_done) begin
            state <= IDLE;
            cnt   <= 8'd0;
            busy  <= 1'b0;
          end else if (tick && (cnt > 8'd1)) begin
            cnt <= cnt - 8'd1;
          end
        end

        default: begin
          state       <= IDLE;
          cnt         <= 8'd0;
          play_sound  <= 13'd0;
          grant_alarm <= 1'b0;
          grant_key   <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piezo_arbiter.sv
// Testbench for piezo_arbiter: directed scenarios plus a randomized run,
// compared every cycle against a transaction-level reference model.
module tb_piezo_arbiter;

  localparam int BEEP_T = 5;
  localparam int GAP_T  = 2;

  localparam int M_IDLE  = 0;
  localparam int M_ALARM = 1;
  localparam int M_BEEP  = 2;
  localparam int M_GAP   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        alarm_req = 1'b0;
  logic [12:0] alarm_note = 13'd0;
  logic        key_req = 1'b0;
  logic [12:0] key_note = 13'd0;
  logic [12:0] play_sound;
  logic        grant_alarm;
  logic        grant_key;
  logic        busy;

  piezo_arbiter #(.BEEP_TICKS(BEEP_T), .GAP_TICKS(GAP_T)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .alarm_req(alarm_req), .alarm_note(alarm_note),
    .key_req(key_req), .key_note(key_note),
    .play_sound(play_sound), .grant_alarm(grant_alarm),
    .grant_key(grant_key), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: which job owns the speaker, how many ticks of the
  // current timed job have elapsed, and a waiting-key queue of depth one.
  int          m_mode;
  int          m_done;
  logic [12:0] m_sound;
  logic [12:0] pq[$];

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_done  = 0;
    m_sound = 13'd0;
    pq.delete();
  endtask

  task automatic model_step();
    bit          had_pend;
    logic [12:0] pnote;
    bit          leave;
    had_pend = (pq.size() != 0);
    pnote    = had_pend ? pq[0] : 13'd0;
    if (m_mode == M_IDLE) begin
      if (had_pend || key_req) begin
        m_mode  = M_BEEP;
        m_done  = 0;
        m_sound = had_pend ? pnote : key_note;
        pq.delete();
      end else if (alarm_req) begin
        m_mode  = M_ALARM;
        m_sound = alarm_note;
      end
    end else begin
      if (key_req && !had_pend) pq.push_back(key_note);
      case (m_mode)
        M_ALARM: begin
          leave = !alarm_req;
`ifdef KEY_PREEMPT_EN
          if (had_pend) leave = 1'b1;
`endif
          if (leave) begin
            m_mode = M_GAP; m_done = 0; m_sound = 13'd0;
          end else begin
            m_sound = alarm_note;
          end
        end
        M_BEEP: begin
          if (tick) m_done++;
          if (m_done == BEEP_T) begin
            m_mode = M_GAP; m_done = 0; m_sound = 13'd0;
          end
        end
        default: begin
          if (tick) m_done++;
          if (m_done == GAP_T) begin
            m_mode = M_IDLE; m_done = 0; m_sound = 13'd0;
          end
        end
      endcase
    end
  endtask

  task automatic cmp_outputs(input string tag);
    chk({tag, ".play_sound"}, 32'(play_sound), 32'(m_sound));
    chk({tag, ".grant_alarm"}, 32'(grant_alarm), 32'(m_mode == M_ALARM));
    chk({tag, ".grant_key"}, 32'(grant_key), 32'(m_mode == M_BEEP));
    chk({tag, ".busy"}, 32'(busy), 32'(m_mode != M_IDLE));
  endtask

  bit tick_rand = 0;
  int cyc_n     = 0;
  int beep_ticks, gap_ticks, key_rises, snd8_cycles;
  bit prev_gk;

  // One clock: pick tick, advance model, let DUT clock, compare at +1.
  task automatic cyc(input string tag);
    if (tick_rand) tick = ($urandom_range(0, 2) == 0);
    else           tick = ((cyc_n % 4) == 3);
    if (grant_key && tick) beep_ticks++;
    if (busy && !grant_key && !grant_alarm && tick) gap_ticks++;
    prev_gk = grant_key;
    model_step();
    @(posedge clk);
    #1;
    cyc_n++;
    key_req = 1'b0;
    cmp_outputs(tag);
    if (grant_key && !prev_gk) key_rises++;
    if (play_sound == 13'h008) snd8_cycles++;
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  task automatic clr_stats();
    beep_ticks = 0; gap_ticks = 0; key_rises = 0; snd8_cycles = 0;
  endtask

  task automatic press(input logic [12:0] note);
    key_req  = 1'b1;
    key_note = note;
  endtask

  initial begin
    bit hit;
    model_reset();
    clr_stats();
    @(posedge clk);
    #1;
    cmp_outputs("reset");
    rst = 1'b0;

    // Idle key press, tick every 4 clk.
    run("idle0", 3);
    clr_stats();
    press(13'h004);
    run("idle_key", 50);
    chk("idle_key.beep_ticks", 32'(beep_ticks), 32'(BEEP_T));
    chk("idle_key.gap_ticks", 32'(gap_ticks), 32'(GAP_T));
    chk("idle_key.beeps", 32'(key_rises), 32'd1);

    // Alarm pass-through with stepping note.
    alarm_req = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      alarm_note = 13'(n);
      cyc("alarm_pass");
    end
    alarm_req = 1'b0;
    clr_stats();
    run("alarm_drop", 30);
    chk("alarm_drop.gap_ticks", 32'(gap_ticks), 32'(GAP_T));

    // Simultaneous key and alarm in IDLE.
    alarm_note = 13'h0a5;
    alarm_req  = 1'b1;
    press(13'h007);
    run("simul", 60);
    chk("simul.grant_alarm_after", 32'(grant_alarm), 32'd1);
    alarm_req = 1'b0;
    run("simul_drop", 30);

    // Key press during alarm.
    alarm_req  = 1'b1;
    alarm_note = 13'h111;
    run("kda_pre", 10);
    press(13'h009);
    run("kda", 80);
    alarm_req = 1'b0;
    run("kda_drop", 70);

    // Double press while the first is still pending.
    clr_stats();
    alarm_req  = 1'b1;
    alarm_note = 13'h033;
    run("dbl_pre", 8);
    press(13'h002);
    cyc("dbl");
    cyc("dbl");
    press(13'h008);
    run("dbl", 40);
    alarm_req = 1'b0;
    run("dbl_drop", 80);
    chk("dbl.beeps", 32'(key_rises), 32'd1);
    chk("dbl.note8_cycles", 32'(snd8_cycles), 32'd0);

    // Reset in the middle of a beep.
    clr_stats();
    press(13'h015);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      cyc("rst_beep");
      if (beep_ticks == 3) hit = 1;
    end
    chk("rst_beep.reached_tick3", 32'(hit), 32'd1);
    chk("rst_beep.granted", 32'(grant_key), 32'd1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_beep.async_sound", 32'(play_sound), 32'd0);
    chk("rst_beep.async_busy", 32'(busy), 32'd0);
    #1;
    rst = 1'b0;
    run("rst_after", 30);
    chk("rst_after.busy", 32'(busy), 32'd0);

    // Randomized traffic.
    tick_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) alarm_req = ~alarm_req;
      alarm_note = 13'($urandom);
      if ($urandom_range(0, 24) == 0) press(13'($urandom));
      else key_note = 13'($urandom);
      cyc("rand");
    end
    alarm_req = 1'b0;
    run("rand_tail", 100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/piezo_arbiter.md
PIEZO_ARBITER -- requirements
Module: piezo_arbiter

Interface
REQ-001 Parameter BEEP_TICKS, default 5, sets key-beep duration in tick periods (legal range 1..255).
REQ-002 Parameter GAP_TICKS, default 2, sets the silence between grants in tick periods (legal range 1..255).
REQ-003 Port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port tick, input, 1 bit: one-clk enable pulse from the clock divider; this is the timing base for durations.
REQ-006 Port alarm_req, input, 1 bit: level request from the alarm FSM; held high while the alarm wants the speaker.
REQ-007 Port alarm_note, input, 13 bits: note code from the alarm FSM; this code is passed through live while the alarm holds the grant.
REQ-008 Port key_req, input, 1 bit: one-clk pulse on a keypad press.
REQ-009 Port key_note, input, 13 bits: note code for the key beep; sampled in the same cycle that key_req is high.
REQ-010 Port play_sound, output, 13 bits: registered note code to the piezo driver; 0 means silence.
REQ-011 Port grant_alarm, output, 1 bit: registered; high while in ALARM.
REQ-012 Port grant_key, output, 1 bit: registered; high while in BEEP.
REQ-013 Port busy, output, 1 bit: registered; high in every state except IDLE.

Function
REQ-014 The block SHALL implement a four-state FSM: IDLE, ALARM, BEEP, GAP.
REQ-015 A key_req pulse SHALL set a one-deep pending flag and latch key_note; pulses that arrive while the flag is already set SHALL be dropped, and the first latched note is kept.
REQ-016 In IDLE, a pending key SHALL win: next state BEEP and pending cleared. Otherwise, alarm_req high SHALL give next state ALARM. Otherwise the FSM stays in IDLE.
REQ-017 A key_req and alarm_req arriving in the same IDLE cycle SHALL go to BEEP; the alarm is served after the following GAP.
REQ-018 In ALARM, play_sound SHALL equal alarm_note delayed by one clk. When alarm_req falls, the next state SHALL be GAP.
REQ-019 In BEEP, play_sound SHALL hold the latched key note for exactly BEEP_TICKS tick pulses, then the next state SHALL be GAP.
REQ-020 In GAP, play_sound SHALL be 0 for exactly GAP_TICKS tick pulses, then the next state SHALL be IDLE.
REQ-021 Durations SHALL use an 8-bit down-counter. It is loaded with N on state entry and decremented on each tick; the state exits on the clk where tick=1 and the counter equals 1.
REQ-022 Cycles without a tick SHALL NOT decrement the counter. There is no wrap-around: the counter never decrements below 1.
REQ-023 Arbitration latency SHALL be one clk: outputs reflect the new state on the clk after the deciding edge.
REQ-024 play_sound SHALL be 0 in IDLE and in GAP.

Reset
REQ-025 Asserting rst SHALL immediately force IDLE, counter=0, pending flag=0, latched note=0, play_sound=0, grant_alarm=0, grant_key=0 and busy=0.
REQ-026 Reset asserted during ALARM or BEEP SHALL silence the output at once. After release, the FSM resumes from IDLE; there is no pending carry-over.
REQ-027 The first clk edge after rst deasserts SHALL evaluate the IDLE rules normally.

Configuration
REQ-028 With macro KEY_PREEMPT_EN defined, a pending key during ALARM SHALL force ALARM to GAP, then BEEP on the next IDLE decision. The alarm regains the grant after the post-beep GAP if alarm_req is still high.
REQ-029 Without KEY_PREEMPT_EN, a pending key during ALARM SHALL stay pending until the alarm releases. It is served after the GAP that follows the alarm.

Verification
REQ-030 Idle key press: key_req=1 with key_note=13'h004, tick every 4 clk. Required: grant_key high and play_sound=13'h004 for 5 ticks, then 2 ticks of 0, then busy=0.
REQ-031 Alarm pass-through: alarm_req=1 with alarm_note stepping 13'h001 to 13'h010. Required: play_sound follows one clk later; alarm_req low gives GAP of 2 ticks, then IDLE.
REQ-032 Simultaneous requests in IDLE: key_req and alarm_req in the same clk. Required: BEEP first, then GAP, then ALARM.
REQ-033 Key press during alarm: key_req during ALARM. Required with KEY_PREEMPT_EN: GAP, BEEP, GAP, ALARM. Required without it: the alarm continues; the beep plays after alarm_req drops and a GAP.
REQ-034 Double press: key_req 13'h002, then 13'h008 while the first is still pending. Required: only 13'h002 beeps, once.
REQ-035 Reset mid-beep: rst pulse at tick 3 of BEEP. Required: play_sound=0 and busy=0 asynchronously; after release, the FSM is in IDLE with no beep.
